// File: rtl/sdp_ram_fifo_pkg.sv
// Shared constants, width helpers and output-stage state type for the SDP RAM FIFO controller.
package sdp_ram_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    // ram_used needs one extra bit so that a full RAM can be told apart from an empty one
    function automatic int used_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int count_width(input int addr_width);
        return addr_width + 2;
    endfunction

    typedef enum logic [1:0] {
        OUT_EMPTY         = 2'b00,
        OUT_PENDING       = 2'b01,
        OUT_VALID         = 2'b10,
        OUT_VALID_PENDING = 2'b11
    } out_state_e;

endpackage

// File: rtl/sdp_ram_fifo_out_stage.sv
// Output register stage: hides the RAM read latency and grants read-issue permission.
module sdp_ram_fifo_out_stage
    import sdp_ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_issue,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  m_ready,
    output logic                  issue_ok,
    output logic                  m_valid_nxt,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data
);

    logic                  rd_pending_r;
    logic                  m_valid_r;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic                  m_valid_nxt_s;
    logic [DATA_WIDTH-1:0] m_data_nxt_s;
    out_state_e            state_s;

    // Stage state decoded from the two occupancy flags
    always_comb begin
        state_s = out_state_e'({m_valid_r, rd_pending_r});
    end

    // Landing reads and pops; a read may only be issued if the register is free at landing
    always_comb begin
        m_valid_nxt_s = m_valid_r;
        m_data_nxt_s  = m_data_r;
        issue_ok      = 1'b0;
        case (state_s)
            OUT_EMPTY: begin
                issue_ok = 1'b1;
            end
            OUT_PENDING, OUT_VALID_PENDING: begin
                m_valid_nxt_s = 1'b1;
                m_data_nxt_s  = rd_data;
            end
            OUT_VALID: begin
                issue_ok      = m_ready;
                m_valid_nxt_s = ~m_ready;
            end
            default: begin
                m_valid_nxt_s = 1'b0;
                m_data_nxt_s  = m_data_r;
                issue_ok      = 1'b0;
            end
        endcase
    end

    // Stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending_r <= 1'b0;
            m_valid_r    <= 1'b0;
            m_data_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_pending_r <= rd_issue;
            m_valid_r    <= m_valid_nxt_s;
            m_data_r     <= m_data_nxt_s;
        end
    end

    assign m_valid_nxt = m_valid_nxt_s;
    assign m_valid     = m_valid_r;
    assign m_data      = m_data_r;

endmodule

// File: rtl/sdp_ram_fifo_ctrl.sv
// Valid/ready FIFO controller driving a simple dual-port RAM (port A write, port B read).
// Optional almost_full/almost_empty flags are built when SDP_RAM_FIFO_ALMOST_FLAGS_EN is defined.
module sdp_ram_fifo_ctrl
    import sdp_ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
`ifdef SDP_RAM_FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AF_THRESH = (2**ADDR_WIDTH) - 2,
    parameter int AE_THRESH = 1
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [ADDR_WIDTH+1:0]   count,
    output logic                    full,
    output logic                    empty,
`ifdef SDP_RAM_FIFO_ALMOST_FLAGS_EN
    output logic                    almost_full,
    output logic                    almost_empty,
`endif
    output logic                    ram_wr_en_a,
    output logic                    ram_rd_en_a,
    output logic [ADDR_WIDTH-1:0]   ram_addr_a,
    output logic [DATA_WIDTH-1:0]   ram_wdata_a,
    output logic                    ram_wr_en_b,
    output logic                    ram_rd_en_b,
    output logic [ADDR_WIDTH-1:0]   ram_addr_b,
    output logic [DATA_WIDTH-1:0]   ram_wdata_b,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_b
);

    localparam int UW    = used_width(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [UW-1:0]         ram_used_r;
    logic [UW-1:0]         ram_used_nxt_s;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nxt_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  push_s;
    logic                  rd_issue_s;
    logic                  issue_ok_s;
    logic                  m_valid_nxt_s;

    assign s_ready    = rst_n & ~full_r;
    assign push_s     = s_valid & s_ready;
    // Issue decision looks only at registered occupancy, never at this cycle's push
    assign rd_issue_s = (ram_used_r != {UW{1'b0}}) & issue_ok_s;

    sdp_ram_fifo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_issue    (rd_issue_s),
        .rd_data     (ram_rdata_b),
        .m_ready     (m_ready),
        .issue_ok    (issue_ok_s),
        .m_valid_nxt (m_valid_nxt_s),
        .m_valid     (m_valid),
        .m_data      (m_data)
    );

    // Next RAM occupancy and total words held after this edge
    always_comb begin
        ram_used_nxt_s = ram_used_r;
        case ({push_s, rd_issue_s})
            2'b10:   ram_used_nxt_s = ram_used_r + UW'(1);
            2'b01:   ram_used_nxt_s = ram_used_r - UW'(1);
            default: ram_used_nxt_s = ram_used_r;
        endcase
        count_nxt_s = CW'(ram_used_nxt_s) + CW'(rd_issue_s) + CW'(m_valid_nxt_s);
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
            ram_used_r <= {UW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_issue_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            ram_used_r <= ram_used_nxt_s;
            count_r    <= count_nxt_s;
            full_r     <= (ram_used_nxt_s == DEPTH_U);
            empty_r    <= (count_nxt_s == {CW{1'b0}});
        end
    end

`ifdef SDP_RAM_FIFO_ALMOST_FLAGS_EN
    logic almost_full_r;
    logic almost_empty_r;

    // Threshold flags, registered from the same next-state values as full/empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            almost_full_r  <= (int'(ram_used_nxt_s) >= AF_THRESH);
            almost_empty_r <= (int'(count_nxt_s) <= AE_THRESH);
        end
    end

    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
`endif

    assign count       = count_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign ram_wr_en_a = push_s;
    assign ram_rd_en_a = 1'b0;
    assign ram_addr_a  = wr_ptr_r;
    assign ram_wdata_a = s_data;
    assign ram_wr_en_b = 1'b0;
    assign ram_rd_en_b = rd_issue_s;
    assign ram_addr_b  = rd_ptr_r;
    assign ram_wdata_b = {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_sdp_ram_fifo_ctrl.sv
// Self-checking bench for sdp_ram_fifo_ctrl: behavioural RAM, queue reference model, directed + random steps.
`timescale 1ns/1ps
module tb_sdp_ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic          full;
    logic          empty;
`ifdef SDP_RAM_FIFO_ALMOST_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif
    logic          ram_wr_en_a;
    logic          ram_rd_en_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_wdata_a;
    logic          ram_wr_en_b;
    logic          ram_rd_en_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_wdata_b;
    logic [DW-1:0] ram_rdata_b;

    int            tests = 0;
    int            fails = 0;
    int            wr_wraps = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    sdp_ram_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
`ifdef SDP_RAM_FIFO_ALMOST_FLAGS_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .ram_wr_en_a  (ram_wr_en_a),
        .ram_rd_en_a  (ram_rd_en_a),
        .ram_addr_a   (ram_addr_a),
        .ram_wdata_a  (ram_wdata_a),
        .ram_wr_en_b  (ram_wr_en_b),
        .ram_rd_en_b  (ram_rd_en_b),
        .ram_addr_b   (ram_addr_b),
        .ram_wdata_b  (ram_wdata_b),
        .ram_rdata_b  (ram_rdata_b)
    );

    // Behavioural simple dual-port RAM with one-cycle registered read
    always @(posedge clk) begin
        if (ram_wr_en_a) mem[ram_addr_a] <= ram_wdata_a;
        if (ram_rd_en_b) ram_rdata_b <= mem[ram_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: words held = pushes - pops, popped words come out in push order
    always @(negedge clk) begin
        if (rst_n) begin
            check("count_model", 32'(count), 32'(model_q.size()));
            check("empty_model", 32'(empty), 32'(model_q.size() == 0));
            check("s_ready_not_full", 32'(s_ready), 32'(!full));
            if (ram_wr_en_a && ram_rd_en_b)
                check("addr_collision", 32'(ram_addr_a != ram_addr_b), 32'd1);
            if (ram_wr_en_a)
                check("wdata_passthru", 32'(ram_wdata_a), 32'(s_data));
            if (m_valid && m_ready) begin
                if (model_q.size() == 0) begin
                    check("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    check("pop_data", 32'(m_data), 32'(model_q[0]));
                    void'(model_q.pop_front());
                end
            end
            if (s_valid && s_ready) begin
                model_q.push_back(s_data);
                if (ram_addr_a == AW'(DEPTH - 1)) wr_wraps++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int c = 0;
        while (!(empty && model_q.size() == 0) && c < 400) begin
            tick();
            c++;
        end
        check(tag, 32'(c < 400), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        int            next;
        int            c;
        logic          acc;

        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h3C;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_wr_en_a", 32'(ram_wr_en_a), 32'd0);
        check("rst_rd_en_b", 32'(ram_rd_en_b), 32'd0);
        check("tie_rd_en_a", 32'(ram_rd_en_a), 32'd0);
        check("tie_wr_en_b", 32'(ram_wr_en_b), 32'd0);
        check("tie_wdata_b", 32'(ram_wdata_b), 32'd0);
`ifdef SDP_RAM_FIFO_ALMOST_FLAGS_EN
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
`endif
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Two words, latency of the first one
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        tick();
        s_data = 8'h55;
        check("lat_n1", 32'(m_valid), 32'd0);
        tick();
        s_valid = 1'b0;
        check("lat_n2_pre", 32'(m_valid), 32'd0);
        tick();
        check("lat_valid", 32'(m_valid), 32'd1);
        check("lat_data", 32'(m_data), 32'hAA);
        wait_drain("drain_two");
        check("two_empty", 32'(empty), 32'd1);

        // Slow fill with the consumer stalled; one word sits in the output register
        m_ready = 1'b0;
        for (int n = 1; n <= DEPTH + 1; n++) begin
            s_valid = 1'b1;
            s_data  = DW'(n - 1);
            tick();
            s_valid = 1'b0;
            tick();
            tick();
            check("fill_count", 32'(count), 32'(n));
            check("fill_full", 32'(full), 32'(n == DEPTH + 1));
            check("fill_s_ready", 32'(s_ready), 32'(n != DEPTH + 1));
`ifdef SDP_RAM_FIFO_ALMOST_FLAGS_EN
            check("fill_almost_full", 32'(almost_full), 32'((n - 1) >= DEPTH - 2));
            check("fill_almost_empty", 32'(almost_empty), 32'(n <= 1));
`endif
        end
        s_valid = 1'b1;
        s_data  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            check("full_no_wr", 32'(ram_wr_en_a), 32'd0);
            tick();
            check("full_count_hold", 32'(count), 32'(DEPTH + 1));
        end
        s_valid = 1'b0;

        // Output held under backpressure
        held = m_data;
        check("hold_first_word", 32'(held), 32'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data", 32'(m_data), 32'(held));
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_no_issue", 32'(ram_rd_en_b), 32'd0);
        end
        m_ready = 1'b1;
        wait_drain("drain_full");

        // Random push/pop of 40 sequential words
        wr_wraps = 0;
        next = 0;
        c = 0;
        while (next < 40 && c < 3000) begin
            s_valid = 1'($urandom_range(0, 3) != 0);
            s_data  = DW'(next);
            m_ready = 1'($urandom_range(0, 1));
            acc     = s_valid && s_ready;
            tick();
            if (acc) next++;
            c++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        check("rand_all_pushed", 32'(next), 32'd40);
        wait_drain("drain_rand");
        check("rand_wraps", 32'(wr_wraps >= 2), 32'd1);

        // Asynchronous reset in the middle of a drain
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(8'hA0 + i);
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        m_ready = 1'b1;
        tick();
        check("pre_rst_count", 32'(count), 32'd6);
        #2;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        check("arst_m_valid", 32'(m_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_s_ready", 32'(s_ready), 32'd0);
        check("arst_rd_en_b", 32'(ram_rd_en_b), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        s_valid = 1'b1;
        s_data  = 8'h77;
        tick();
        s_valid = 1'b0;
        c = 0;
        while (!m_valid && c < 20) begin
            tick();
            c++;
        end
        check("post_rst_valid", 32'(m_valid), 32'd1);
        check("post_rst_data", 32'(m_data), 32'h77);
        wait_drain("drain_post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
